lcd_pclk_gen: RTL



---
 rtl/lcd_pclk_gen_if.sv | 44 ++++
 rtl/lcd_pclk_gen.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/lcd_pclk_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : lcd_pclk_gen_if
//  Purpose  : Bundles the panel-ID input and the pixel-clock outputs of
//             lcd_pclk_gen into one interface.
//  Modports : master - the clock generator (samples lcd_id, drives clock side)
//             slave  - the consumer side (panel-ID reader / LCD timing logic)
//  Signals  : lcd_id  [15:0]   panel ID, synchronous to sys_clk
//             pclk             divided pixel clock
//             pclk_en          strobe in the first high cycle of each period
//             bypass           ratio is 1, consumer runs on sys_clk + pclk_en
//             locked           generator running on a stable ratio
//             cur_div [DIV_W]  ratio in use, 0 = output disabled
//  Revision : 1.0  initial release
// ============================================================================
interface lcd_pclk_gen_if #(
    parameter int DIV_W = 8
);
    logic [15:0]      lcd_id;
    logic             pclk;
    logic             pclk_en;
    logic             bypass;
    logic             locked;
    logic [DIV_W-1:0] cur_div;

    modport master (
        input  lcd_id,
        output pclk,
        output pclk_en,
        output bypass,
        output locked,
        output cur_div
    );

    modport slave (
        output lcd_id,
        input  pclk,
        input  pclk_en,
        input  bypass,
        input  locked,
        input  cur_div
    );
endinterface
`default_nettype wire

// File: rtl/lcd_pclk_gen.sv
`default_nettype none
// ============================================================================
//  Module   : lcd_pclk_gen
//  Purpose  : Table-driven integer divider producing the LCD pixel clock from
//             sys_clk. The ratio is looked up from the panel ID; a change of
//             ID drains the current period, holds pclk low for GAP_CYC cycles
//             and reloads the ratio, so no short pulse is ever emitted.
//  Ports    : sys_clk  system clock
//             sys_rst  asynchronous active-low reset
//             bus      lcd_pclk_gen_if.master (lcd_id in; pclk, pclk_en,
//                      bypass, locked, cur_div out - all registered)
//  Revision : 1.0  initial release
// ============================================================================
module lcd_pclk_gen #(
    parameter int               DIV_W   = 8,
    parameter int               GAP_CYC = 4,
    parameter logic [15:0]      ID0     = 16'h4342,
    parameter logic [15:0]      ID1     = 16'h7084,
    parameter logic [15:0]      ID2     = 16'h7016,
    parameter logic [15:0]      ID3     = 16'h4384,
    parameter logic [15:0]      ID4     = 16'h1018,
    parameter logic [DIV_W-1:0] DIV0    = DIV_W'(8),
    parameter logic [DIV_W-1:0] DIV1    = DIV_W'(4),
    parameter logic [DIV_W-1:0] DIV2    = DIV_W'(1),
    parameter logic [DIV_W-1:0] DIV3    = DIV_W'(4),
    parameter logic [DIV_W-1:0] DIV4    = DIV_W'(1),
    parameter logic [DIV_W-1:0] DEF_DIV = '0
) (
    input  wire logic         sys_clk,
    input  wire logic         sys_rst,
    lcd_pclk_gen_if.master    bus
);

    localparam int GW = $clog2(GAP_CYC + 1);
    localparam logic [GW-1:0]    GAP_LOAD = GW'(GAP_CYC);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    typedef enum logic [2:0] {
        ST_GAP   = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_IDLE  = 3'd4
    } state_t;

    state_t           state_q,   state_d;
    logic [GW-1:0]    gap_q,     gap_d;
    logic [DIV_W-1:0] cnt_q,     cnt_d;
    logic [15:0]      id_q,      id_d;
    logic [DIV_W-1:0] cur_div_q, cur_div_d;
    logic             pclk_q,    pclk_d;
    logic             pclk_en_q, pclk_en_d;
    logic             bypass_q,  bypass_d;
    logic             locked_q,  locked_d;

    logic [DIV_W-1:0] lut_div;
    logic [DIV_W-1:0] div_hi;
    logic [DIV_W-1:0] cnt_nxt;
    logic             cnt_last;
    logic             pclk_rule;
    logic             id_chg;

    // Lookup is evaluated highest index first so that a match on a lower
    // index overrides it: ID0 wins if several entries carry the same ID.
    always_comb begin
        lut_div = DEF_DIV;
        if (bus.lcd_id == ID4) lut_div = DIV4;
        if (bus.lcd_id == ID3) lut_div = DIV3;
        if (bus.lcd_id == ID2) lut_div = DIV2;
        if (bus.lcd_id == ID1) lut_div = DIV1;
        if (bus.lcd_id == ID0) lut_div = DIV0;
    end

    // High phase length H = div - floor(div/2): odd ratios get the extra
    // cycle in the high phase.
    assign div_hi    = cur_div_q - (cur_div_q >> 1);
    assign cnt_last  = (cnt_q == cur_div_q - DIV_ONE);
    assign cnt_nxt   = cnt_last ? '0 : cnt_q + DIV_ONE;
    assign pclk_rule = (cnt_q < div_hi);
    assign id_chg    = (bus.lcd_id != id_q);

    always_comb begin
        state_d   = state_q;
        gap_d     = gap_q;
        cnt_d     = cnt_q;
        id_d      = id_q;
        cur_div_d = cur_div_q;
        pclk_d    = 1'b0;
        pclk_en_d = 1'b0;
        bypass_d  = bypass_q;
        locked_d  = locked_q;

        case (state_q)
            ST_GAP: begin
                locked_d = 1'b0;
                bypass_d = 1'b0;
                if (gap_q != '0) begin
                    gap_d = gap_q - GW'(1);
                end
                if (gap_q <= GW'(1)) begin
                    state_d = ST_LOAD;
                end
            end

            ST_LOAD: begin
                id_d      = bus.lcd_id;
                cur_div_d = lut_div;
                cnt_d     = '0;
                locked_d  = 1'b0;
                bypass_d  = 1'b0;
                state_d   = (lut_div == '0) ? ST_IDLE : ST_RUN;
            end

            ST_RUN: begin
                if (cur_div_q == DIV_ONE) begin
                    // pclk is never high in bypass, so an ID change can go
                    // straight to the low gap.
                    if (id_chg) begin
                        state_d  = ST_GAP;
                        gap_d    = GAP_LOAD;
                        locked_d = 1'b0;
                        bypass_d = 1'b0;
                    end else begin
                        pclk_en_d = 1'b1;
                        bypass_d  = 1'b1;
                        locked_d  = 1'b1;
                    end
                end else begin
                    pclk_d = pclk_rule;
                    cnt_d  = cnt_nxt;
                    if (id_chg) begin
                        // The detecting cycle already follows drain rules;
                        // if it is the last low cycle the period is complete.
                        locked_d = 1'b0;
                        if (cnt_last) begin
                            state_d = ST_GAP;
                            gap_d   = GAP_LOAD;
                        end else begin
                            state_d = ST_DRAIN;
                        end
                    end else begin
                        pclk_en_d = (cnt_q == '0);
                        locked_d  = locked_q | (cnt_q == '0);
                    end
                end
            end

            ST_DRAIN: begin
                pclk_d   = pclk_rule;
                cnt_d    = cnt_nxt;
                locked_d = 1'b0;
                if (cnt_last) begin
                    state_d = ST_GAP;
                    gap_d   = GAP_LOAD;
                end
            end

            ST_IDLE: begin
                cur_div_d = '0;
                locked_d  = 1'b0;
                bypass_d  = 1'b0;
                if (id_chg) begin
                    state_d = ST_GAP;
                    gap_d   = GAP_LOAD;
                end
            end

            default: begin
                state_d  = ST_GAP;
                gap_d    = GAP_LOAD;
                locked_d = 1'b0;
                bypass_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q   <= ST_GAP;
            gap_q     <= GAP_LOAD;
            cnt_q     <= '0;
            id_q      <= '0;
            cur_div_q <= '0;
            pclk_q    <= 1'b0;
            pclk_en_q <= 1'b0;
            bypass_q  <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            gap_q     <= gap_d;
            cnt_q     <= cnt_d;
            id_q      <= id_d;
            cur_div_q <= cur_div_d;
            pclk_q    <= pclk_d;
            pclk_en_q <= pclk_en_d;
            bypass_q  <= bypass_d;
            locked_q  <= locked_d;
        end
    end

    assign bus.pclk    = pclk_q;
    assign bus.pclk_en = pclk_en_q;
    assign bus.bypass  = bypass_q;
    assign bus.locked  = locked_q;
    assign bus.cur_div = cur_div_q;

endmodule
`default_nettype wire
